// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and clear-engine state encoding for the byte-lane register file.
package regfile_pkg;
    localparam int BYTE_W = 8;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_LANES = 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: write port, two read ports and clear handshake of the register file.
interface multiport_register_file_if import regfile_pkg::*; #(
    parameter int LANES = DEFAULT_LANES,
    parameter int ADDR_W = 5
);
    logic [LANES-1:0] wr_en;
    logic [LANES*ADDR_W-1:0] wr_addr;
    logic [LANES*BYTE_W-1:0] wr_data;
    logic [LANES-1:0] rda_en;
    logic [LANES*ADDR_W-1:0] rda_addr;
    logic [LANES*BYTE_W-1:0] rda_data;
    logic rda_valid;
    logic [LANES-1:0] rdb_en;
    logic [LANES*ADDR_W-1:0] rdb_addr;
    logic [LANES*BYTE_W-1:0] rdb_data;
    logic rdb_valid;
    logic clear_req;
    logic busy;
    modport master (
        output wr_en, wr_addr, wr_data, rda_en, rda_addr, rdb_en, rdb_addr, clear_req,
        input rda_data, rda_valid, rdb_data, rdb_valid, busy
    );
    modport slave (
        input wr_en, wr_addr, wr_data, rda_en, rda_addr, rdb_en, rdb_addr, clear_req,
        output rda_data, rda_valid, rdb_data, rdb_valid, busy
    );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: registered per-lane read with enable/busy/zero-reg masking;
// same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port import regfile_pkg::*; #(
    parameter int LANES = DEFAULT_LANES,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int ADDR_W = 5,
    parameter int ZERO_REG = 0
)(
    input  logic clock,
    input  logic reset,
    input  logic [DEPTH-1:0][BYTE_W-1:0] mem,
    input  logic busy,
    input  logic [LANES-1:0] en,
    input  logic [LANES*ADDR_W-1:0] addr,
`ifdef REGFILE_BYPASS_EN
    input  logic [LANES-1:0] wr_en,
    input  logic [LANES*ADDR_W-1:0] wr_addr,
    input  logic [LANES*BYTE_W-1:0] wr_data,
`endif
    output logic [LANES*BYTE_W-1:0] data,
    output logic valid
);
    logic [LANES*BYTE_W-1:0] nxt;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ADDR_W-1:0] a;
        logic [BYTE_W-1:0] word;
        assign a = addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        // wr_en arrives already gated by busy/clear; later lanes override earlier ones
        always_comb begin
            word = mem[a];
            for (int j = 0; j < LANES; j++)
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) word = wr_data[j*BYTE_W +: BYTE_W];
        end
`else
        assign word = mem[a];
`endif
        assign nxt[k*BYTE_W +: BYTE_W] = (!en[k] || busy || (ZERO_REG != 0 && a == '0)) ? '0 : word;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            data <= '0;
            valid <= 1'b0;
        end else begin
            data <= nxt;
            valid <= |en;
        end
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: byte-lane register file, one write port, two registered read ports,
// sequential clear engine. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module multiport_register_file import regfile_pkg::*; #(
    parameter int LANES = DEFAULT_LANES,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ZERO_REG = 0
)(
    input logic clock,
    input logic reset,
    multiport_register_file_if.slave bus
);
    logic [DEPTH-1:0][BYTE_W-1:0] mem;
    logic [1:0] state;
    logic [ADDR_W-1:0] cnt;
    logic busy;
    logic [LANES-1:0] wr_ok;
    assign busy = state != IDLE;
    // a clear request in the same cycle as a write takes precedence
    assign wr_ok = bus.wr_en & {LANES{!busy && !bus.clear_req}};
    assign bus.busy = busy;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state == IDLE ? (bus.clear_req ? CLEAR : IDLE) :
                     state == CLEAR ? (cnt == ADDR_W'(DEPTH - 1) ? DONE : CLEAR) : IDLE;
            cnt <= state == CLEAR ? cnt + 1'b1 : '0;
        end
    always_ff @(posedge clock or posedge reset)
        if (reset)
            mem <= '0;
        else if (state == CLEAR)
            mem[cnt] <= '0;
        else
            for (int k = 0; k < LANES; k++)
                if (wr_ok[k] && (ZERO_REG == 0 || bus.wr_addr[k*ADDR_W +: ADDR_W] != '0))
                    mem[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= bus.wr_data[k*BYTE_W +: BYTE_W];
    regfile_read_port #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rda (
        .clock(clock), .reset(reset), .mem(mem), .busy(busy),
        .en(bus.rda_en), .addr(bus.rda_addr),
`ifdef REGFILE_BYPASS_EN
        .wr_en(wr_ok), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
`endif
        .data(bus.rda_data), .valid(bus.rda_valid)
    );
    regfile_read_port #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rdb (
        .clock(clock), .reset(reset), .mem(mem), .busy(busy),
        .en(bus.rdb_en), .addr(bus.rdb_addr),
`ifdef REGFILE_BYPASS_EN
        .wr_en(wr_ok), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
`endif
        .data(bus.rdb_data), .valid(bus.rdb_valid)
    );
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: scoreboard bench driving a ZERO_REG=0 and a ZERO_REG=1 instance in lockstep.
module tb_multiport_register_file;
    localparam int L = 2, D = 32, AW = 5;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    logic [L-1:0] wr_en, rda_en, rdb_en;
    logic [L*AW-1:0] wr_addr, rda_addr, rdb_addr;
    logic [L*8-1:0] wr_data;
    logic clear_req;
    multiport_register_file_if #(.LANES(L), .ADDR_W(AW)) b0 ();
    multiport_register_file_if #(.LANES(L), .ADDR_W(AW)) b1 ();
    assign b0.wr_en = wr_en;     assign b1.wr_en = wr_en;
    assign b0.wr_addr = wr_addr; assign b1.wr_addr = wr_addr;
    assign b0.wr_data = wr_data; assign b1.wr_data = wr_data;
    assign b0.rda_en = rda_en;   assign b1.rda_en = rda_en;
    assign b0.rda_addr = rda_addr; assign b1.rda_addr = rda_addr;
    assign b0.rdb_en = rdb_en;   assign b1.rdb_en = rdb_en;
    assign b0.rdb_addr = rdb_addr; assign b1.rdb_addr = rdb_addr;
    assign b0.clear_req = clear_req; assign b1.clear_req = clear_req;
    multiport_register_file #(.LANES(L), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(0)) u0 (
        .clock(clock), .reset(reset), .bus(b0));
    multiport_register_file #(.LANES(L), .DEPTH(D), .ADDR_W(AW), .ZERO_REG(1)) u1 (
        .clock(clock), .reset(reset), .bus(b1));

    typedef struct {
        logic [15:0] a0, b0, a1, b1;
        logic va, vb, busy;
    } exp_t;
    exp_t q[$];
    logic [7:0] m [2][D];
    int st, cnt, n_run = 0, n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(int z, logic e, logic [AW-1:0] a);
        logic [7:0] v;
        if (!e || st != 0 || (z != 0 && a == 0)) return 8'h00;
        v = m[z][a];
`ifdef REGFILE_BYPASS_EN
        if (!clear_req)
            for (int j = 0; j < L; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*8 +: 8];
`endif
        return v;
    endfunction

    function automatic logic [15:0] rport(int z, logic [L-1:0] e, logic [L*AW-1:0] ad);
        return {rd(z, e[1], ad[AW +: AW]), rd(z, e[0], ad[0 +: AW])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m[0][i] = 8'h00;
            m[1][i] = 8'h00;
        end
        st = 0;
        cnt = 0;
    endtask

    task automatic step();
        exp_t e;
        e.a0 = rport(0, rda_en, rda_addr);
        e.b0 = rport(0, rdb_en, rdb_addr);
        e.a1 = rport(1, rda_en, rda_addr);
        e.b1 = rport(1, rdb_en, rdb_addr);
        e.va = |rda_en;
        e.vb = |rdb_en;
        if (st == 0) begin
            if (clear_req) begin
                st = 1;
                cnt = 0;
            end else
                for (int j = 0; j < L; j++)
                    if (wr_en[j]) begin
                        m[0][wr_addr[j*AW +: AW]] = wr_data[j*8 +: 8];
                        if (wr_addr[j*AW +: AW] != 0) m[1][wr_addr[j*AW +: AW]] = wr_data[j*8 +: 8];
                    end
        end else if (st == 1) begin
            m[0][cnt] = 8'h00;
            m[1][cnt] = 8'h00;
            if (cnt == D - 1) st = 2;
            else cnt++;
        end else
            st = 0;
        e.busy = st != 0;
        q.push_back(e);
        @(posedge clock);
        #1;
        e = q.pop_front();
        check("rda_data0", 32'(b0.rda_data), 32'(e.a0));
        check("rdb_data0", 32'(b0.rdb_data), 32'(e.b0));
        check("rda_data1", 32'(b1.rda_data), 32'(e.a1));
        check("rdb_data1", 32'(b1.rdb_data), 32'(e.b1));
        check("rda_valid", 32'({b1.rda_valid, b0.rda_valid}), 32'({e.va, e.va}));
        check("rdb_valid", 32'({b1.rdb_valid, b0.rdb_valid}), 32'({e.vb, e.vb}));
        check("busy", 32'({b1.busy, b0.busy}), 32'({e.busy, e.busy}));
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rda_en = '0; rda_addr = '0; rdb_en = '0; rdb_addr = '0;
        clear_req = 1'b0;
    endtask

    initial begin
        int bcount;
        idle();
        model_reset();
        #2;
        check("rst_rda_data", 32'(b0.rda_data), 32'h0);
        check("rst_valid", 32'({b0.rda_valid, b0.rdb_valid}), 32'h0);
        check("rst_busy", 32'(b0.busy), 32'h0);
        reset = 1'b0;
        // two lanes to distinct addresses, then read back on port A
        wr_en = 2'b11; wr_addr = {5'd7, 5'd3}; wr_data = {8'h5A, 8'hA5};
        step();
        idle();
        rda_en = 2'b11; rda_addr = {5'd7, 5'd3};
        step();
        check("t1_rda", 32'(b0.rda_data), 32'h5AA5);
        idle();
        rdb_en = 2'b01; rdb_addr = {5'd7, 5'd3};
        step();
        check("t2_rdb", 32'(b0.rdb_data), 32'h00A5);
        idle();
        step();
        // lane collision: lane 1 data must land
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {8'h11, 8'h22};
        step();
        idle();
        rda_en = 2'b11; rda_addr = {5'd9, 5'd9};
        step();
        check("t3_rda", 32'(b0.rda_data), 32'h1111);
        for (int i = 0; i < D; i += 2) begin
            idle();
            wr_en = 2'b11; wr_addr = {5'(i + 1), 5'(i)}; wr_data = 16'hFFFF;
            step();
        end
        idle();
        clear_req = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = 16'h0012;
        step();
        bcount = int'(b0.busy);
        for (int i = 0; i < D + 3; i++) begin
            idle();
            clear_req = (i == 4);
            wr_en = 2'b11; wr_addr = {5'd1, 5'd2}; wr_data = 16'h5555;
            rda_en = 2'b11; rda_addr = {5'd1, 5'd2}; rdb_en = 2'b10; rdb_addr = {5'd5, 5'd0};
            step();
            bcount += int'(b0.busy);
        end
        check("t4_busy_len", 32'(bcount), 32'(D + 1));
        for (int i = 0; i < D; i += 2) begin
            idle();
            rda_en = 2'b11; rda_addr = {5'(i + 1), 5'(i)};
            rdb_en = 2'b11; rdb_addr = {5'(i), 5'(i + 1)};
            step();
        end
        // abort a clear by reset partway through
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = 16'h0099;
        step();
        idle();
        clear_req = 1'b1;
        step();
        idle();
        rda_en = 2'b11; rdb_en = 2'b01;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        #1;
        check("t5_busy", 32'({b1.busy, b0.busy}), 32'h0);
        check("t5_valid", 32'({b0.rda_valid, b0.rdb_valid}), 32'h0);
        check("t5_data", 32'({b0.rda_data, b0.rdb_data}), 32'h0);
        model_reset();
        #2;
        reset = 1'b0;
        idle();
        rda_en = 2'b11; rda_addr = {5'd3, 5'd20};
        step();
        // same-cycle write/read; expectation depends on forwarding build
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = 16'h0010;
        step();
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = 16'h003C;
        rda_en = 2'b01; rda_addr = {5'd0, 5'd4};
        step();
`ifdef REGFILE_BYPASS_EN
        check("t6_bypass", 32'(b0.rda_data), 32'h003C);
`else
        check("t6_nobypass", 32'(b0.rda_data), 32'h0010);
`endif
        idle();
        wr_en = 2'b10; wr_addr = {5'd0, 5'd1}; wr_data = 16'h7700;
        step();
        idle();
        rda_en = 2'b11; rda_addr = {5'd0, 5'd0};
        step();
        check("t6_zr1", 32'(b1.rda_data), 32'h0000);
        check("t6_zr0", 32'(b0.rda_data), 32'h7777);
        for (int i = 0; i < 60; i++) begin
            wr_en = L'($urandom); wr_addr = (L*AW)'($urandom); wr_data = (L*8)'($urandom);
            rda_en = L'($urandom); rda_addr = (L*AW)'($urandom);
            rdb_en = L'($urandom); rdb_addr = (L*AW)'($urandom);
            clear_req = 1'b0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
